reglk_bank: RTL
===============

Name: reglk_bank

Overview:
- Parametrised successor to the single-purpose lock-bit array: a bank of NUM_REGS lock words, WIDTH bits each, that gate writes to protected registers across the SoC.
- Lock bits are sticky once the system leaves boot. They clear only on global reset or after a qualified JTAG debug unlock.
- A block-local reset request cannot drop locks at runtime; attempts are flagged and counted.
- Sits beside the peripheral register fabric; reglk_o fans out to the per-peripheral write gates.

Parameters:
- NUM_REGS, 6, number of lock words.
- WIDTH, 32, bits per lock word.
- UNLOCK_HOLD, 16, consecutive cycles jtag_unlock_i must stay high before locks clear.
- RESET_VAL, '1, per-word value loaded on reset or relock (WIDTH bits, same for all words).
- AW, $clog2(NUM_REGS) (min 1), write address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  global reset.
- boot_done_i  in  1  level; boot firmware has finished lock programming.
- jtag_unlock_i  in  1  level; authenticated debug unlock request.
- rst_lk_i  in  1  block-local reset request.
- wr_valid_i  in  1  write request.
- wr_ready_o  out  1  write accepted when wr_valid_i && wr_ready_o.
- wr_addr_i  in  AW  lock word index.
- wr_data_i  in  WIDTH  write data.
- wr_mask_i  in  WIDTH  per-bit write enable.
- wr_err_o  out  1  one-cycle error pulse.
- reglk_o  out  NUM_REGS*WIDTH  flattened lock words; word j at [j*WIDTH +: WIDTH].
- state_o  out  2  current FSM state.
- alert_o  out  1  one-cycle security alert pulse.
- viol_cnt_o  out  8  violation count.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: all words = RESET_VAL, state = BOOT, wr_err_o = 0, alert_o = 0, viol_cnt_o = 0. wr_ready_o is combinational from state.
- State encodings: BOOT = 0, SECURE = 1, UNLOCK_WAIT = 2, DEBUG = 3.
- BOOT:
  - Writes are replace-under-mask: word = (word & ~mask) | (data & mask).
  - rst_lk_i reloads RESET_VAL.
  - boot_done_i → SECURE.
- SECURE:
  - Writes are set-only: word = word | (data & mask).
  - A write attempting to clear a set bit (mask & ~data & word != 0) has its set bits applied, its clears dropped, and pulses wr_err_o and alert_o the following cycle.
  - rst_lk_i is ignored; it pulses alert_o and is counted as a violation. A held level counts once per rising edge.
  - jtag_unlock_i → UNLOCK_WAIT, counter = 1.
- UNLOCK_WAIT:
  - wr_ready_o = 0.
  - Counter increments each cycle while jtag_unlock_i = 1. If jtag_unlock_i drops → SECURE, counter cleared.
  - When counter reaches UNLOCK_HOLD → DEBUG, all words cleared to 0 on that same edge.
- DEBUG:
  - Writes are replace-under-mask.
  - rst_lk_i clears all words to 0.
  - jtag_unlock_i falls → SECURE with all words reloaded to RESET_VAL (relock; never leave debug-cleared locks live).
- Write timing:
  - Writes take effect on the edge of acceptance; reglk_o reflects them the next cycle.
  - Address >= NUM_REGS: no update, wr_err_o pulses the next cycle. In SECURE this is also a violation.
- Simultaneous events:
  - Accepted write and a state transition on the same edge: the write applies under the current state's rule, and the transition then overrides it where it reloads/clears.
  - boot_done_i and jtag_unlock_i together in BOOT: go to SECURE only.
- Violation counter: saturates at 255. It clears only on rst_i.
- rst_i mid-UNLOCK_WAIT or DEBUG returns to BOOT with RESET_VAL.

Optional Feature:
- Macro: REGLK_VIOL_CNT_EN.
- Defined: viol_cnt_o counts as described.
- Undefined: no counter flops, viol_cnt_o tied to 0; alert_o behaviour unchanged.

Decomposition:
- Package reglk_pkg holds:
  - reglk_state_e enum (BOOT, SECURE, UNLOCK_WAIT, DEBUG; 2-bit).
  - VIOL_CNT_W = 8.
  - Function for the update rule: apply(word, data, mask, state).
- One natural sub-module, reglk_unlock_qual: the UNLOCK_HOLD counter and qualification, producing unlock_ok and unlock_abort to the main FSM.

Test Plan:
- Reset, write addr 2 data 0 mask '1, boot_done_i = 1, then SECURE write addr 2 data 0 mask '1 → word 2 = 0x00000000, then unchanged 0x00000000 (set-only, no clear error since bits already 0).
- SECURE with word 0 = 0xFFFFFFFF, write data 0x0000FFFF mask '1 → word 0 stays 0xFFFFFFFF, wr_err_o and alert_o pulse once, viol_cnt_o = 1.
- SECURE, rst_lk_i held high 5 cycles → all words unchanged, alert_o one pulse, viol_cnt_o += 1.
- SECURE, jtag_unlock_i high 10 cycles then low → back to SECURE, locks intact. Hold it 16 cycles → state_o = 3, reglk_o = 0.
- In DEBUG, write addr 1 = 0x12345678, drop jtag_unlock_i → SECURE, all words = 0xFFFFFFFF.
- Write addr 7 (NUM_REGS = 6) → wr_err_o pulses, no word changes; with REGLK_VIOL_CNT_EN undefined, viol_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/reglk_pkg.sv
// Shared types and the lock-word update rule for the reglk_bank lock-bit array.
package reglk_pkg;

  typedef enum logic [1:0] {
    BOOT        = 2'd0,
    SECURE      = 2'd1,
    UNLOCK_WAIT = 2'd2,
    DEBUG       = 2'd3
  } reglk_state_e;

  localparam int unsigned VIOL_CNT_W  = 8;
  // Widest lock word the update function handles; words are zero-extended into it.
  localparam int unsigned REGLK_MAX_W = 64;

  // New value of one lock word after an accepted write in the given state.
  function automatic logic [REGLK_MAX_W-1:0] apply(
    input logic [REGLK_MAX_W-1:0] word,
    input logic [REGLK_MAX_W-1:0] data,
    input logic [REGLK_MAX_W-1:0] mask,
    input reglk_state_e           state
  );
    logic [REGLK_MAX_W-1:0] res;
    case (state)
      BOOT, DEBUG: res = (word & ~mask) | (data & mask);
      SECURE:      res = word | (data & mask);
      default:     res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reglk_unlock_qual.sv
// Qualifies a JTAG unlock request: it must stay high for UNLOCK_HOLD
// consecutive cycles (counting the SECURE cycle that started the wait).
module reglk_unlock_qual #(
  parameter int unsigned UNLOCK_HOLD = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic wait_i,
  input  logic jtag_unlock_i,
  output logic unlock_ok_o,
  output logic unlock_abort_o
);

  localparam int unsigned CW = $clog2(UNLOCK_HOLD + 1);

  logic [CW-1:0] r_cnt;

  // The edge that would bring the count to UNLOCK_HOLD is the qualifying edge.
  assign unlock_ok_o    = wait_i && jtag_unlock_i && (r_cnt >= CW'(UNLOCK_HOLD - 1));
  assign unlock_abort_o = wait_i && !jtag_unlock_i;

  // Hold counter: seeded to 1 on entry, advances while the request stays high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (start_i && jtag_unlock_i) begin
      r_cnt <= CW'(1);
    end else if (wait_i && jtag_unlock_i && !unlock_ok_o) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/reglk_bank.sv
// Bank of NUM_REGS sticky lock words gating peripheral register writes.
// Optional macro REGLK_VIOL_CNT_EN: when defined, viol_cnt_o counts security
// violations (saturating); otherwise viol_cnt_o is tied to zero.
// WIDTH must not exceed reglk_pkg::REGLK_MAX_W.
module reglk_bank
  import reglk_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 6,
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       UNLOCK_HOLD = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL   = '1,
  parameter int unsigned       AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      boot_done_i,
  input  logic                      jtag_unlock_i,
  input  logic                      rst_lk_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [AW-1:0]             wr_addr_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic [WIDTH-1:0]          wr_mask_i,
  output logic                      wr_err_o,
  output logic [NUM_REGS*WIDTH-1:0] reglk_o,
  output logic [1:0]                state_o,
  output logic                      alert_o,
  output logic [VIOL_CNT_W-1:0]     viol_cnt_o
);

  reglk_state_e                   r_state;
  reglk_state_e                   w_state_nxt;
  logic [NUM_REGS-1:0][WIDTH-1:0] r_words;
  logic                           r_wr_err;
  logic                           r_alert;
  logic                           r_rst_lk_q;

  logic             w_acc;
  logic             w_addr_ok;
  logic             w_wr_en;
  logic             w_clr_att;
  logic             w_rst_lk_rise;
  logic             w_viol;
  logic             w_unlock_ok;
  logic             w_unlock_abort;
  logic [WIDTH-1:0] w_cur_word;
  logic [WIDTH-1:0] w_new_word;

  reglk_unlock_qual #(
    .UNLOCK_HOLD(UNLOCK_HOLD)
  ) u_unlock_qual (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (r_state == SECURE),
    .wait_i         (r_state == UNLOCK_WAIT),
    .jtag_unlock_i  (jtag_unlock_i),
    .unlock_ok_o    (w_unlock_ok),
    .unlock_abort_o (w_unlock_abort)
  );

  assign wr_ready_o    = (r_state != UNLOCK_WAIT);
  assign w_acc         = wr_valid_i && wr_ready_o;
  assign w_addr_ok     = 32'(wr_addr_i) < NUM_REGS;
  assign w_wr_en       = w_acc && w_addr_ok;
  assign w_new_word    = WIDTH'(apply(REGLK_MAX_W'(w_cur_word), REGLK_MAX_W'(wr_data_i),
                                      REGLK_MAX_W'(wr_mask_i), r_state));
  assign w_clr_att     = w_wr_en && (r_state == SECURE) &&
                         (|(wr_mask_i & ~wr_data_i & w_cur_word));
  assign w_rst_lk_rise = rst_lk_i && !r_rst_lk_q;
  assign w_viol        = (r_state == SECURE) &&
                         (w_clr_att || (w_acc && !w_addr_ok) || w_rst_lk_rise);

  assign reglk_o  = r_words;
  assign state_o  = r_state;
  assign wr_err_o = r_wr_err;
  assign alert_o  = r_alert;

  // Read the addressed word (zero when the address is out of range).
  always_comb begin
    w_cur_word = '0;
    for (int unsigned j = 0; j < NUM_REGS; j++) begin
      if (wr_addr_i == AW'(j)) w_cur_word = r_words[j];
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= BOOT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; boot_done wins over a concurrent unlock request in BOOT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:        if (boot_done_i) w_state_nxt = SECURE;
      SECURE:      if (jtag_unlock_i) w_state_nxt = UNLOCK_WAIT;
      UNLOCK_WAIT: begin
        if (w_unlock_abort)   w_state_nxt = SECURE;
        else if (w_unlock_ok) w_state_nxt = DEBUG;
      end
      DEBUG:       if (!jtag_unlock_i) w_state_nxt = SECURE;
      default:     w_state_nxt = BOOT;
    endcase
  end

  // Lock words: the write lands first, later bulk reload/clear assignments override it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_words <= {NUM_REGS{RESET_VAL}};
    end else begin
      for (int unsigned j = 0; j < NUM_REGS; j++) begin
        if (w_wr_en && (wr_addr_i == AW'(j))) r_words[j] <= w_new_word;
      end
      if ((r_state == BOOT) && rst_lk_i)              r_words <= {NUM_REGS{RESET_VAL}};
      if ((r_state == UNLOCK_WAIT) && w_unlock_ok)    r_words <= '0;
      if ((r_state == DEBUG) && rst_lk_i)             r_words <= '0;
      if ((r_state == DEBUG) && !jtag_unlock_i)       r_words <= {NUM_REGS{RESET_VAL}};
    end
  end

  // Registered error/alert pulses and rst_lk edge tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_err   <= 1'b0;
      r_alert    <= 1'b0;
      r_rst_lk_q <= 1'b0;
    end else begin
      r_wr_err   <= (w_acc && !w_addr_ok) || w_clr_att;
      r_alert    <= w_viol;
      r_rst_lk_q <= rst_lk_i;
    end
  end

`ifdef REGLK_VIOL_CNT_EN
  logic [VIOL_CNT_W-1:0] r_viol_cnt;

  // Saturating violation counter, cleared only by global reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_viol_cnt <= '0;
    end else if (w_viol && (r_viol_cnt != '1)) begin
      r_viol_cnt <= r_viol_cnt + 1'b1;
    end
  end

  assign viol_cnt_o = r_viol_cnt;
`else
  assign viol_cnt_o = '0;
`endif

endmodule
